// File: rtl/token_ring_pkg.sv
// rtl/token_ring_pkg.sv - shared FSM state enum and index-width helper for the token ring arbiter
package token_ring_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int MAX_STATIONS = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/token_ring_arbiter_if.sv
// rtl/token_ring_arbiter_if.sv - request/release/grant bundle between ring stations and the arbiter
interface token_ring_arbiter_if #(
  parameter int N_STATIONS = 4
);
  import token_ring_pkg::*;

  localparam int IDX_W = idx_w(N_STATIONS);

  logic                  init;
  logic                  enable;
  logic [N_STATIONS-1:0] req;
  logic [N_STATIONS-1:0] rel;
  logic [N_STATIONS-1:0] grant;
  logic [IDX_W-1:0]      tok_pos;
  logic                  tok_valid;

  modport master (
    output init, enable, req, rel,
    input  grant, tok_pos, tok_valid
  );

  modport slave (
    input  init, enable, req, rel,
    output grant, tok_pos, tok_valid
  );

endinterface

// File: rtl/token_station.sv
// rtl/token_station.sv - one ring station: masks its req/release by token presence and holds its grant flop
module token_station
  import token_ring_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic here,
  input  logic req,
  input  logic rel,
  input  logic set_grant,
  input  logic clr_grant,
  output logic req_here,
  output logic rel_here,
  output logic grant
);

  // Only the station holding the token may influence the ring.
  assign req_here = here & req;
  assign rel_here = here & rel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant <= 1'b0;
    end else if (enable) begin
      if (clr_grant) begin
        grant <= 1'b0;
      end else if (set_grant && here) begin
        grant <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/token_ring_arbiter.sv
// rtl/token_ring_arbiter.sv - token ring arbiter top: ring pointer, IDLE/PASS/HOLD FSM, optional hold cap (TOKEN_HOLD_LIMIT_EN)
module token_ring_arbiter
  import token_ring_pkg::*;
#(
  parameter int N_STATIONS = 4,
  parameter int INIT_POS   = 0,
  parameter int HOLD_MAX   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  token_ring_arbiter_if.slave  bus
);

  localparam int               IDX_W    = idx_w(N_STATIONS);
  localparam logic [IDX_W-1:0] INIT_IDX = IDX_W'(INIT_POS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STATIONS - 1);

  // Out-of-range parameter sets elaborate this marker block so they show up in the hierarchy.
  if (N_STATIONS < 2 || N_STATIONS > MAX_STATIONS || INIT_POS < 0 ||
      INIT_POS >= N_STATIONS || HOLD_MAX < 1) begin : g_illegal_params
  end

  state_t                state;
  logic [IDX_W-1:0]      tok_pos;
  logic [IDX_W-1:0]      next_pos;
  logic                  tok_valid_q;
  logic [N_STATIONS-1:0] grant_q;
  logic [N_STATIONS-1:0] hit_req;
  logic [N_STATIONS-1:0] hit_rel;
  logic                  en;
  logic                  do_init;
  logic                  req_here;
  logic                  rel_here;
  logic                  hold_limit;
  logic                  go_hold;
  logic                  leave_hold;
  logic                  clr_grant;

  assign en       = bus.enable;
  assign do_init  = en & bus.init;
  assign req_here = |hit_req;
  assign rel_here = |hit_rel;
  assign next_pos = (tok_pos == LAST_IDX) ? '0 : tok_pos + 1'b1;

`ifdef TOKEN_HOLD_LIMIT_EN
  localparam int CNT_W = $clog2(HOLD_MAX) + 1;

  logic [CNT_W-1:0] hold_cnt;

  assign hold_limit = (hold_cnt == CNT_W'(HOLD_MAX - 1));

  // Counts enabled HOLD cycles; frozen with the rest of the state while enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (en) begin
      if (bus.init || go_hold) begin
        hold_cnt <= '0;
      end else if (state == HOLD && !leave_hold) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign hold_limit = 1'b0;
`endif

  assign go_hold    = en & ~bus.init & (state == PASS) & req_here;
  assign leave_hold = en & ~bus.init & (state == HOLD) & (rel_here | ~req_here | hold_limit);
  assign clr_grant  = leave_hold | do_init;

  // Init outranks everything; after a release the pointer always moves on, so the
  // released station is only revisited once every other station has seen the token.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tok_pos     <= '0;
      tok_valid_q <= 1'b0;
    end else if (en) begin
      if (bus.init) begin
        state       <= PASS;
        tok_pos     <= INIT_IDX;
        tok_valid_q <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            state       <= IDLE;
            tok_valid_q <= 1'b0;
          end
          PASS: begin
            if (req_here) begin
              state <= HOLD;
            end else begin
              tok_pos <= next_pos;
            end
          end
          HOLD: begin
            if (leave_hold) begin
              state   <= PASS;
              tok_pos <= next_pos;
            end
          end
          default: begin
            state       <= IDLE;
            tok_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < N_STATIONS; i++) begin : g_station
    token_station u_station (
      .clk       (clk),
      .reset     (reset),
      .enable    (en),
      .here      (tok_pos == IDX_W'(i)),
      .req       (bus.req[i]),
      .rel       (bus.rel[i]),
      .set_grant (go_hold),
      .clr_grant (clr_grant),
      .req_here  (hit_req[i]),
      .rel_here  (hit_rel[i]),
      .grant     (grant_q[i])
    );
  end

  assign bus.grant     = en ? grant_q : '0;
  assign bus.tok_pos   = tok_pos;
  assign bus.tok_valid = en & tok_valid_q;

endmodule

// File: tb/tb_token_ring_arbiter.sv
// tb/tb_token_ring_arbiter.sv - directed scoreboard bench for token_ring_arbiter (N=4, INIT_POS=0, HOLD_MAX=3)
module tb_token_ring_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  token_ring_arbiter_if #(.N_STATIONS(N)) bus ();

  token_ring_arbiter #(
    .N_STATIONS (N),
    .INIT_POS   (0),
    .HOLD_MAX   (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return 32'(bus.grant);
      1:       return 32'(bus.tok_pos);
      default: return 32'(bus.tok_valid);
    endcase
  endfunction

  task automatic check_all();
    sb_item_t    it;
    logic [31:0] o;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      o  = observe(it.sel);
      tests++;
      assert (o === it.exp) else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", it.tag, o, it.exp);
      end
    end
  endtask

  task automatic expect3(input string tag, input logic [N-1:0] g, input int p, input logic v);
    sb.push_back('{{tag, "_grant"}, 0, 32'(g)});
    sb.push_back('{{tag, "_pos"},   1, 32'(p)});
    sb.push_back('{{tag, "_valid"}, 2, 32'(v)});
  endtask

  task automatic drive(input logic en, input logic ini, input logic [N-1:0] rq, input logic [N-1:0] rl);
    bus.enable = en;
    bus.init   = ini;
    bus.req    = rq;
    bus.rel    = rl;
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pos;

    reset = 1'b1;
    drive(1'b0, 1'b0, 4'b0000, 4'b0000);
    #1;
    expect3("reset_async", 4'b0000, 0, 1'b0);
    check_all();
    drive(1'b1, 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    expect3("reset_held_en", 4'b0000, 0, 1'b0);
    check_all();
    reset = 1'b0;

    drive(1'b1, 1'b1, 4'b0000, 4'b0000);
    expect3("init", 4'b0000, 0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int k = 1; k <= 6; k++) begin
      expect3("pass_walk", 4'b0000, k % N, 1'b1);
      tick();
    end

    drive(1'b1, 1'b0, 4'b0100, 4'b0000);
    expect3("grant_at_2", 4'b0100, 2, 1'b1);
    tick();
    drive(1'b1, 1'b0, 4'b0101, 4'b1011);
    expect3("foreign_ignored", 4'b0100, 2, 1'b1);
    tick();
    drive(1'b1, 1'b0, 4'b0100, 4'b0100);
    expect3("release_2", 4'b0000, 3, 1'b1);
    tick();

    drive(1'b1, 1'b0, 4'b1111, 4'b1111);
    pos = 3;
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) begin
        expect3("rotate_grant", 4'b0001 << pos, pos, 1'b1);
      end else begin
        pos = (pos + 1) % N;
        expect3("rotate_pass", 4'b0000, pos, 1'b1);
      end
      tick();
    end

    drive(1'b1, 1'b0, 4'b0001, 4'b0000);
    expect3("hold_enter", 4'b0001, 0, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 4'b0001, 4'b0000);
      expect3("frozen", 4'b0000, 0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 4'b0001, 4'b0000);
    expect3("resume_1", 4'b0001, 0, 1'b1);
    tick();
    expect3("resume_2", 4'b0001, 0, 1'b1);
    tick();
`ifdef TOKEN_HOLD_LIMIT_EN
    expect3("limit_release", 4'b0000, 1, 1'b1);
    tick();
`else
    drive(1'b1, 1'b0, 4'b0000, 4'b0000);
    expect3("req_drop_release", 4'b0000, 1, 1'b1);
    tick();
`endif

    drive(1'b1, 1'b0, 4'b0010, 4'b0000);
`ifdef TOKEN_HOLD_LIMIT_EN
    for (int k = 0; k < 3; k++) begin
      expect3("cap_grant", 4'b0010, 1, 1'b1);
      tick();
    end
    expect3("cap_release", 4'b0000, 2, 1'b1);
    tick();
`else
    for (int k = 0; k < 5; k++) begin
      expect3("hold_persist", 4'b0010, 1, 1'b1);
      tick();
    end
    drive(1'b1, 1'b0, 4'b0010, 4'b0010);
    expect3("hold_release", 4'b0000, 2, 1'b1);
    tick();
`endif

    drive(1'b1, 1'b0, 4'b0100, 4'b0000);
    expect3("hold_2", 4'b0100, 2, 1'b1);
    tick();
    drive(1'b1, 1'b1, 4'b0100, 4'b0100);
    expect3("init_in_hold", 4'b0000, 0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 4'b0000, 4'b0000);
    expect3("after_init", 4'b0000, 1, 1'b1);
    tick();

    drive(1'b1, 1'b0, 4'b0010, 4'b0000);
    expect3("hold_1", 4'b0010, 1, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    expect3("reset_mid", 4'b0000, 0, 1'b0);
    check_all();
    #2;
    reset = 1'b0;
    drive(1'b1, 1'b0, 4'b1111, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      expect3("no_token", 4'b0000, 0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 4'b1111, 4'b0000);
    expect3("init_disabled", 4'b0000, 0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 4'b0000, 4'b0000);
    expect3("still_no_token", 4'b0000, 0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 4'b0000, 4'b0000);
    expect3("reinit", 4'b0000, 0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 4'b0001, 4'b0000);
    expect3("regrant", 4'b0001, 0, 1'b1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
